// File: rtl/demux_1to16_deser.sv
// Rebuilds a 16-bit word from one select-addressed bit per cycle: drives sel to an
// upstream 16:1 mux, stores its output at position sel, and commits the word atomically.
module demux_1to16_deser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        d,
  input  logic        d_vld,
  output logic [3:0]  sel,
  output logic [15:0] out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] shadow;

  // Handshake: d is taken on an edge where the block is in CAPTURE, d_vld is high and
  // abort is low; there is no back-pressure, busy/done only report where the frame is.
  logic accept;
  logic last;

  assign accept = (state == CAPTURE) && !abort && d_vld;
  assign last   = accept && (sel == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (abort)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE: begin
        state_next = start ? CAPTURE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CAPTURE);
    done = (state == DONE);
  end

  // sel only returns to 0 through completion or abort, so it never runs past 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= 4'd0;
      shadow <= 16'h0000;
      out    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          sel <= 4'd0;
          if (start) shadow <= 16'h0000;
        end
        CAPTURE: begin
          if (abort) begin
            sel <= 4'd0;
          end else if (accept) begin
            shadow[sel] <= d;
            if (last) begin
              out <= {d, shadow[14:0]};
              sel <= 4'd0;
            end else begin
              sel <= sel + 4'd1;
            end
          end
        end
        DONE: begin
          sel <= 4'd0;
          if (start) shadow <= 16'h0000;
        end
        default: sel <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_1to16_deser.sv
// Bench for demux_1to16_deser: a 16:1 mux model feeds d from sel; a monitor pops
// expected words and completion cycles from queues whenever done is presented.
module tb_demux_1to16_deser;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        d;
  logic        d_vld;
  logic [3:0]  sel;
  logic [15:0] out;
  logic        busy;
  logic        done;

  logic [15:0] mux_in;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  int          cyc = 0;
  int          tests = 0;
  int          failures = 0;

  demux_1to16_deser dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .d     (d),
    .d_vld (d_vld),
    .sel   (sel),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  assign d = mux_in[sel];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest expected frame
  initial begin
    logic [15:0] w;
    int          c;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n === 1'b1 && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          failures++;
          $display("FAIL unexpected_done: got done with out=%h, expected no done", out);
        end else begin
          w = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("out_word", {16'h0, out}, {16'h0, w});
          check("done_cycle", cyc, c);
        end
      end
    end
  end

  // drivers
  task automatic capture(input logic [15:0] w, input bit stall, input bit poke);
    int   k;
    int   n_busy;
    int   stalls;
    bit   got;
    logic [3:0] sel_prev;
    stalls = stall ? 7 : 0;
    @(negedge clk);
    mux_in = w;
    start  = 1'b1;
    d_vld  = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    exp_q.push_back(w);
    exp_cyc_q.push_back(k + 16 + stalls);
    check("start_busy", {31'h0, busy}, 32'd1);
    check("start_sel", {28'h0, sel}, 32'd0);
    n_busy = 1;
    got    = 1'b0;
    for (int j = 0; j < 40 && !got; j++) begin
      @(negedge clk);
      start    = poke && (sel == 4'd4);
      d_vld    = !(stall && (j % 3 == 2));
      sel_prev = sel;
      @(posedge clk);
      #1;
      if (!d_vld) check("stall_sel", {28'h0, sel}, {28'h0, sel_prev});
      if (busy) n_busy++;
      if (done) got = 1'b1;
    end
    check("frame_finished", {31'h0, got}, 32'd1);
    check("busy_cycles", n_busy, 16 + stalls);
    @(negedge clk);
    start = 1'b0;
    d_vld = 1'b0;
  endtask

  initial begin
    int k;
    int n;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    d_vld  = 1'b0;
    mux_in = 16'h0000;
    #1;
    check("rst_out", {16'h0, out}, 32'h0);
    check("rst_sel", {28'h0, sel}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // basic loopback, then one third of cycles stalled (7 stall cycles over 16 bits)
    capture(16'hAA56, 1'b0, 1'b0);
    capture(16'hAA56, 1'b1, 1'b0);

    // abort at sel == 7: no done, out keeps the previous word
    @(negedge clk);
    mux_in = 16'h1234;
    start  = 1'b1;
    d_vld  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (sel != 4'd7 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_sel7", {28'h0, sel}, 32'd7);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_sel", {28'h0, sel}, 32'd0);
    check("abort_done", {31'h0, done}, 32'd0);
    check("abort_out", {16'h0, out}, 32'h0000AA56);
    @(negedge clk);
    abort = 1'b0;
    d_vld = 1'b0;
    repeat (3) @(negedge clk);

    // back-to-back frames with start held high
    mux_in = 16'hFFFF;
    start  = 1'b1;
    d_vld  = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    exp_q.push_back(16'hFFFF);
    exp_cyc_q.push_back(k + 16);
    exp_q.push_back(16'h0001);
    exp_cyc_q.push_back(k + 33);
    repeat (16) @(posedge clk);
    #1;
    check("b2b_done1", {31'h0, done}, 32'd1);
    @(negedge clk);
    mux_in = 16'h0001;
    @(posedge clk);
    #1;
    check("b2b_busy2", {31'h0, busy}, 32'd1);
    check("b2b_sel2", {28'h0, sel}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("b2b_done2", {31'h0, done}, 32'd1);
    @(negedge clk);
    d_vld = 1'b0;
    @(negedge clk);

    // asynchronous reset at sel == 10
    mux_in = 16'hC3C3;
    start  = 1'b1;
    d_vld  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (sel != 4'd10 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reset_reach_sel10", {28'h0, sel}, 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", {16'h0, out}, 32'h0);
    check("mid_rst_sel", {28'h0, sel}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    d_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    capture(16'h5A5A, 1'b0, 1'b0);

    // start pulsed at sel == 4 must not restart the frame
    capture(16'h3C0F, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
